// File: rtl/spi_master_cfg.sv
// spi_master_cfg - parametrised SPI master with runtime mode and clock divider.
//
// Ports:
//   clk, rst          system clock (posedge), asynchronous active-high reset
//   start             transfer request, only honoured while idle
//   tx_data, ss_sel   word to send and slave index, captured on accept
//   cpol, cpha        SPI mode, captured on accept
//   clk_div           SCK half-period is clk_div+1 clk cycles, captured on accept
//   miso              serial input from the slave (already in the clk domain)
//   busy              high from the cycle after accept up to (not incl.) done
//   done              one-cycle completion pulse; rx_data valid with it
//   rx_data           last received word, held between transfers
//   sck, mosi         registered serial clock and data
//   ss_n              one-hot-low slave selects
//
// Sequence: IDLE -> SETUP (H) -> XFER (2*DATA_W*H) -> HOLD (H) -> DONE (1).
// Every output is a register, so the pins change exactly on clk edges.
module spi_master_cfg #(
  parameter int DATA_W    = 8,
  parameter int DIV_W     = 8,
  parameter int NUM_SS    = 1,
  parameter int SEL_W     = 1,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [SEL_W-1:0]  ss_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              miso,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sck,
  output logic              mosi,
  output logic [NUM_SS-1:0] ss_n
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;

  state_t            state_reg;
  logic [DATA_W-1:0] tx_reg;
  logic [DATA_W-1:0] rx_shift_reg;
  logic              cpol_reg;
  logic              cpha_reg;
  logic [DIV_W-1:0]  div_reg;
  logic [DIV_W-1:0]  half_cnt_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;
  // 0 while in the leading half-period of the current bit, 1 in the trailing one
  logic              trail_reg;
  logic [NUM_SS-1:0] sel_dec;

  // Decode the requested slave; an out-of-range index leaves every select high.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SS; gi++) begin : g_sel
      assign sel_dec[gi] = (32'(ss_sel) != gi);
    end
  endgenerate

  // Position in tx/rx words of the k-th bit on the wire.
  function automatic logic [CNT_W-1:0] bit_idx(input logic [CNT_W-1:0] k);
    return LSB_FIRST ? k : (LAST_BIT - k);
  endfunction

  // Shift one received bit in; after DATA_W samples the word is in order.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] r,
                                                 input logic b);
    return LSB_FIRST ? {b, r[DATA_W-1:1]} : {r[DATA_W-2:0], b};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      rx_data      <= '0;
      sck          <= 1'b0;
      mosi         <= 1'b0;
      ss_n         <= '1;
      tx_reg       <= '0;
      rx_shift_reg <= '0;
      cpol_reg     <= 1'b0;
      cpha_reg     <= 1'b0;
      div_reg      <= '0;
      half_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      trail_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg    <= SETUP;
            busy         <= 1'b1;
            tx_reg       <= tx_data;
            cpol_reg     <= cpol;
            cpha_reg     <= cpha;
            div_reg      <= clk_div;
            half_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            trail_reg    <= 1'b0;
            rx_shift_reg <= '0;
            sck          <= cpol;
            ss_n         <= sel_dec;
            // Mode with cpha=0 needs the first bit on the wire before edge 1.
            mosi         <= cpha ? 1'b0 : tx_data[bit_idx(CNT_W'(0))];
          end
        end

        SETUP: begin
          if (half_cnt_reg == div_reg) begin
            // Leading edge of bit 0 starts the first half-period of XFER.
            state_reg    <= XFER;
            half_cnt_reg <= '0;
            sck          <= ~cpol_reg;
            if (cpha_reg) mosi <= tx_reg[bit_idx(CNT_W'(0))];
            else          rx_shift_reg <= shift_in(rx_shift_reg, miso);
          end else begin
            half_cnt_reg <= half_cnt_reg + DIV_W'(1);
          end
        end

        XFER: begin
          if (half_cnt_reg == div_reg) begin
            half_cnt_reg <= '0;
            if (!trail_reg) begin
              // Trailing edge of the current bit.
              trail_reg <= 1'b1;
              sck       <= cpol_reg;
              if (cpha_reg)
                rx_shift_reg <= shift_in(rx_shift_reg, miso);
              else if (bit_cnt_reg != LAST_BIT)
                mosi <= tx_reg[bit_idx(bit_cnt_reg + CNT_W'(1))];
            end else if (bit_cnt_reg == LAST_BIT) begin
              // Last trailing half-period has elapsed; sck already sits at cpol.
              state_reg <= HOLD;
            end else begin
              // Leading edge of the next bit.
              trail_reg   <= 1'b0;
              sck         <= ~cpol_reg;
              bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
              if (cpha_reg) mosi <= tx_reg[bit_idx(bit_cnt_reg + CNT_W'(1))];
              else          rx_shift_reg <= shift_in(rx_shift_reg, miso);
            end
          end else begin
            half_cnt_reg <= half_cnt_reg + DIV_W'(1);
          end
        end

        HOLD: begin
          if (half_cnt_reg == div_reg) begin
            state_reg <= DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
            rx_data   <= rx_shift_reg;
            ss_n      <= '1;
            mosi      <= 1'b0;
          end else begin
            half_cnt_reg <= half_cnt_reg + DIV_W'(1);
          end
        end

        DONE: begin
          // start is deliberately not looked at here; a new request must
          // arrive while idle.
          state_reg <= IDLE;
          done      <= 1'b0;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_cfg.sv
// Testbench for spi_master_cfg. Instance dut: 8-bit MSB-first, four selects,
// driven against a behavioural SPI slave or a mosi->miso loopback. Instance
// dut_b: 12-bit LSB-first loopback. Expected results are queued at start and
// compared when done pulses.
module tb_spi_master_cfg;

  localparam int DW   = 8;
  localparam int NSS  = 4;
  localparam int SW   = 3;
  localparam int DIVW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- instance A ----------------
  logic            start;
  logic [DW-1:0]   tx_data;
  logic [SW-1:0]   ss_sel;
  logic            cpol, cpha;
  logic [DIVW-1:0] clk_div;
  logic            miso;
  logic            busy, done, sck, mosi;
  logic [DW-1:0]   rx_data;
  logic [NSS-1:0]  ss_n;

  spi_master_cfg #(
    .DATA_W(DW), .DIV_W(DIVW), .NUM_SS(NSS), .SEL_W(SW), .LSB_FIRST(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .ss_sel(ss_sel),
    .cpol(cpol), .cpha(cpha), .clk_div(clk_div), .miso(miso),
    .busy(busy), .done(done), .rx_data(rx_data), .sck(sck), .mosi(mosi), .ss_n(ss_n)
  );

  // ---------------- instance B ----------------
  logic        start_b;
  logic [11:0] tx_b;
  logic        busy_b, done_b, sck_b, mosi_b;
  logic [11:0] rx_b;
  logic [0:0]  ss_n_b;

  spi_master_cfg #(
    .DATA_W(12), .DIV_W(4), .NUM_SS(1), .SEL_W(1), .LSB_FIRST(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .tx_data(tx_b), .ss_sel(1'b0),
    .cpol(1'b0), .cpha(1'b0), .clk_div(4'd2), .miso(mosi_b),
    .busy(busy_b), .done(done_b), .rx_data(rx_b), .sck(sck_b), .mosi(mosi_b), .ss_n(ss_n_b)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [7:0]  rx;    // word dut must receive
    logic [7:0]  tx;    // word the slave must capture from mosi
    logic [31:0] lat;   // accept edge -> done edge, in clk cycles
    logic [3:0]  ss;    // ss_n while busy
    logic        cpol;  // sck level when done
  } exp_t;

  exp_t sb[$];

  // ---------------- slave model (instance A) ----------------
  logic [7:0] sl_word = 8'h00;
  logic       cur_cpol = 1'b0, cur_cpha = 1'b0, loop_en = 1'b0;
  logic [7:0] s_tx = 8'h00, s_rx = 8'h00;
  logic       s_miso = 1'b0;
  logic       sck_q = 1'b0, busy_q = 1'b0, done_q = 1'b0;
  int unsigned acc_cyc = 0;
  int          busy_cnt = 0, ss_bad = 0;

  assign miso = loop_en ? mosi : s_miso;

  always @(negedge clk) begin
    busy_q <= busy;
    sck_q  <= sck;
    done_q <= done;
    if (rst) begin
      busy_cnt <= 0;
      ss_bad   <= 0;
    end else begin
      if (done_q) check_eq("done_width", 32'(done), 32'd0);
      if (busy && !busy_q) begin
        acc_cyc  <= cyc;
        busy_cnt <= 1;
        ss_bad   <= (sb.size() > 0 && ss_n === sb[0].ss) ? 0 : 1;
        s_rx     <= 8'h00;
        if (cur_cpha) s_tx <= sl_word;
        else begin
          s_miso <= sl_word[7];
          s_tx   <= {sl_word[6:0], 1'b0};
        end
      end else if (busy) begin
        busy_cnt <= busy_cnt + 1;
        if (sb.size() > 0 && ss_n !== sb[0].ss) ss_bad <= ss_bad + 1;
        if (sck != sck_q) begin
          // Leading edge: sck moves away from its idle level.
          if ((sck != cur_cpol) ^ cur_cpha) s_rx <= {s_rx[6:0], mosi};
          else begin
            s_miso <= s_tx[7];
            s_tx   <= {s_tx[6:0], 1'b0};
          end
        end
      end
      if (done) begin
        check_eq("sb_pending", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          check_eq("rx_data", 32'(rx_data), 32'(sb[0].rx));
          check_eq("mosi_word", 32'(s_rx), 32'(sb[0].tx));
          check_eq("latency", cyc - acc_cyc, sb[0].lat);
          check_eq("busy_cycles", 32'(busy_cnt), sb[0].lat);
          check_eq("ss_n_busy_bad", 32'(ss_bad), 32'd0);
          check_eq("ss_n_done", 32'(ss_n), 32'hF);
          check_eq("sck_idle", 32'(sck), 32'(sb[0].cpol));
          check_eq("busy_at_done", 32'(busy), 32'd0);
          void'(sb.pop_front());
        end
      end
    end
  end

  // ---------------- mosi capture (instance B) ----------------
  logic [11:0] cap_b = 12'h000;
  logic        sck_b_q = 1'b0, busy_b_q = 1'b0;

  always @(negedge clk) begin
    sck_b_q  <= sck_b;
    busy_b_q <= busy_b;
    if (busy_b && !busy_b_q) cap_b <= 12'h000;
    else if (busy_b && busy_b_q && sck_b && !sck_b_q) cap_b <= {mosi_b, cap_b[11:1]};
  end

  // ---------------- driver ----------------
  task automatic wait_idle();
    int k = 0;
    while ((busy || done) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 3000) check_eq("idle_timeout", 32'({busy, done}), 32'd0);
  endtask

  task automatic wait_drain(input int limit);
    int k = 0;
    while (sb.size() != 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (k >= limit) check_eq("done_timeout", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic issue(input logic [7:0] tx, input logic [2:0] sel, input logic pol,
                       input logic pha, input logic [7:0] div, input logic [7:0] sw,
                       input logic lp);
    exp_t e;
    wait_idle();
    @(negedge clk);
    cur_cpol = pol;
    cur_cpha = pha;
    sl_word  = sw;
    loop_en  = lp;
    tx_data  = tx;
    ss_sel   = sel;
    cpol     = pol;
    cpha     = pha;
    clk_div  = div;
    start    = 1'b1;
    e.rx   = lp ? tx : sw;
    e.tx   = tx;
    e.lat  = 32'(18 * (int'(div) + 1));
    e.ss   = (sel < 3'd4) ? ~(4'b0001 << sel) : 4'hF;
    e.cpol = pol;
    sb.push_back(e);
    @(negedge clk);
    start   = 1'b0;
    // Inputs changing after accept must not disturb the transfer.
    tx_data = 8'($urandom);
    ss_sel  = 3'($urandom);
    cpol    = 1'($urandom);
    cpha    = 1'($urandom);
    clk_div = 8'($urandom);
  endtask

  initial begin
    int unsigned acc_b;
    int k;
    rst     = 1'b1;
    start   = 1'b0;
    tx_data = '0;
    ss_sel  = '0;
    cpol    = 1'b0;
    cpha    = 1'b0;
    clk_div = '0;
    start_b = 1'b0;
    tx_b    = 12'h801;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_rx", 32'(rx_data), 32'd0);
    check_eq("rst_sck", 32'(sck), 32'd0);
    check_eq("rst_mosi", 32'(mosi), 32'd0);
    check_eq("rst_ss_n", 32'(ss_n), 32'hF);

    // mode 0, loopback, H=2 -> 36 cycles
    issue(8'hA5, 3'd0, 1'b0, 1'b0, 8'd1, 8'h00, 1'b1);
    wait_drain(500);
    // mode 3, slave answers 0xC3, H=1
    issue(8'h3C, 3'd0, 1'b1, 1'b1, 8'd0, 8'hC3, 1'b0);
    wait_drain(500);
    // mode 1 with a start pulse in mid-transfer that must be ignored
    issue(8'h96, 3'd1, 1'b0, 1'b1, 8'd2, 8'h5A, 1'b0);
    repeat (10) @(negedge clk);
    tx_data = 8'hFF;
    clk_div = 8'd5;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain(500);

    // reset during bit 4 of a mode-0 transfer (H=2)
    issue(8'h5A, 3'd3, 1'b0, 1'b0, 8'd1, 8'h00, 1'b1);
    repeat (18) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    sb.delete();
    check_eq("midrst_sck", 32'(sck), 32'd0);
    check_eq("midrst_ss_n", 32'(ss_n), 32'hF);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_rx", 32'(rx_data), 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(8'h69, 3'd3, 1'b1, 1'b0, 8'd3, 8'h81, 1'b0);
    wait_drain(500);

    // select decoding: index 2, then out-of-range index 5
    issue(8'h11, 3'd2, 1'b0, 1'b0, 8'd0, 8'hEE, 1'b0);
    wait_drain(500);
    issue(8'h22, 3'd5, 1'b1, 1'b1, 8'd1, 8'h00, 1'b1);
    wait_drain(500);
    // maximum divider: H=256
    issue(8'hC5, 3'd1, 1'b0, 1'b0, 8'hFF, 8'h3A, 1'b0);
    wait_drain(6000);
    wait_idle();

    // 12-bit LSB-first loopback, H=3 -> 78 cycles
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    tx_b    = 12'h5A5;
    acc_b   = cyc;
    k = 0;
    while (!done_b && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) check_eq("b_done_timeout", 32'(done_b), 32'd1);
    else begin
      check_eq("b_rx_data", 32'(rx_b), 32'h801);
      check_eq("b_mosi_seq", 32'(cap_b), 32'h801);
      check_eq("b_latency", cyc - acc_b, 32'd78);
      check_eq("b_ss_n_done", 32'(ss_n_b), 32'd1);
    end
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
